decode_buffer: RTL and testbench
================================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: decoded-entry capacity; power of two, >=2.
REQ-002 SHALL have parameter MULDIV_EN, default 1: 1 = RV64M ops legal; 0 = RV64M ops flagged illegal.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-004 SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  buffer accepts.
- in_instr  in  32  raw instruction.
- in_pc  in  64  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head.
- out_ctl  out  contral_t  decoded op/alufunc/regwrite.
- out_instr  out  32  head raw instruction.
- out_pc  out  64  head PC.
- out_illegal  out  1  head entry is an illegal instruction.
- count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-005 SHALL push when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-006 SHALL drive in_ready = (count < DEPTH); no push when full, even if a pop occurs in the same cycle.
REQ-007 SHALL decode at push time and store {ctl, illegal, instr, pc}; the head is registered, with no bypass.
REQ-008 SHALL make a pushed entry visible on out_* no earlier than the cycle after the push (latency 1).
REQ-009 SHALL hold out_* and out_valid stable while out_valid && !out_ready.
REQ-010 SHALL decode the RV64I base, Zicsr and RV64M ops with the existing op/alufunc encodings: ALUI, ALU, ALUIW, ALUW, LUI, AUIPC, JAL, JALR, branches, LD, SD, CSR/CSRI.
REQ-011 SHALL set illegal=1 for any of:
- unknown opcode;
- branch f3 010/011;
- CSR f3 000/100;
- R-type funct7 outside {0000000, 0100000, 0000001};
- funct7=0100000 with an f3 other than ADD/SR;
- funct7=0000001 when MULDIV_EN=0.
REQ-012 SHALL on illegal force ctl.op=UNKNOWN, alufunc=NOTALU, regwrite=0.
REQ-013 SHALL force regwrite=0 when rd (instr[11:7]) == 0.
REQ-014 SHALL update count +1 on push-only, -1 on pop-only, and leave it unchanged on simultaneous push and pop.
REQ-015 SHALL wrap read/write pointers modulo DEPTH.
REQ-016 SHALL make flush take priority over push and pop in the same cycle: next cycle count=0, out_valid=0, and the push is discarded.
REQ-017 SHALL not assert out_valid when count=0.

Reset
REQ-018 SHALL on reset asynchronously clear:
- count, pointers and out_valid to 0;
- out_ctl to {UNKNOWN, NOTALU, 0};
- out_instr, out_pc and out_illegal to 0.
REQ-019 SHALL drop all entries when reset asserts mid-operation; in_ready=1 from the first cycle after deassertion.

Structure
REQ-020 SHALL keep contral_t, the op/alufunc enums and the F7/F3/F7_FIRST constants in package pipes; common provides u32/u64.
REQ-021 SHALL place the pure combinational decode in sub-module decode_core (instr, MULDIV_EN in; ctl, illegal out), with the FIFO storage and control in decode_buffer.

Verification
REQ-022 SHALL cover: push 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, op=ALUI, alufunc=ALU_ADD, regwrite=1, illegal=0.
REQ-023 SHALL cover: push 0x022081B3 (mul x3,x1,x2):
- MULDIV_EN=1 -> ALU/ALU_MULT, illegal=0;
- MULDIV_EN=0 -> UNKNOWN/NOTALU, illegal=1, regwrite=0.
REQ-024 SHALL cover: push 0x00000013 (nop) -> ALUI/ALU_ADD, regwrite=0.
REQ-025 SHALL cover: DEPTH=4, out_ready=0, push 5 instrs -> after 4 pushes count=4 and in_ready=0; the 5th is held; draining returns the PCs in push order.
REQ-026 SHALL cover:
- count=2 with simultaneous push and pop -> count stays 2;
- count=3 with flush plus push -> next cycle count=0, out_valid=0.
REQ-027 SHALL cover: assert reset with count=3 -> count=0 and out_valid=0 immediately (async); first push after release appears at the head 1 cycle later.

Source files
------------

// File: rtl/common_pkg.sv
// Shared scalar typedefs used across the pipeline packages.
package common;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

endpackage

// File: rtl/pipes_pkg.sv
// Decode-stage vocabulary: op/alufunc encodings, control bundle, opcode and funct constants.
package pipes;

    import common::*;

    typedef enum logic [3:0] {
        UNKNOWN = 4'd0,
        ALUI,
        ALU,
        ALUIW,
        ALUW,
        LUI,
        AUIPC,
        JAL,
        JALR,
        BRANCH,
        LD,
        SD,
        CSR,
        CSRI
    } op_t;

    typedef enum logic [4:0] {
        NOTALU = 5'd0,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MULT,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alufunc_t;

    typedef struct packed {
        op_t      op;
        alufunc_t alufunc;
        logic     regwrite;
    } contral_t;

    localparam contral_t CTL_NONE = '{op: UNKNOWN, alufunc: NOTALU, regwrite: 1'b0};

    // One buffered, already-decoded instruction.
    typedef struct packed {
        contral_t ctl;
        logic     illegal;
        u32       instr;
        u64       pc;
    } entry_t;

    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;
    localparam logic [6:0] OPC_ALUIW  = 7'b0011011;
    localparam logic [6:0] OPC_ALUW   = 7'b0111011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int unsigned F7_FIRST = 25;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Integer ALU function from funct3; alt selects arithmetic right shift.
    function automatic alufunc_t alu_func(input logic [2:0] f3, input logic alt);
        alufunc_t f;
        f = NOTALU;
        case (f3)
            F3_ADD:  f = ALU_ADD;
            F3_SLL:  f = ALU_SLL;
            F3_SLT:  f = ALU_SLT;
            F3_SLTU: f = ALU_SLTU;
            F3_XOR:  f = ALU_XOR;
            F3_SR:   f = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   f = ALU_OR;
            F3_AND:  f = ALU_AND;
            default: f = NOTALU;
        endcase
        return f;
    endfunction

    function automatic alufunc_t muldiv_func(input logic [2:0] f3);
        alufunc_t f;
        f = NOTALU;
        case (f3)
            F3_MUL:    f = ALU_MULT;
            F3_MULH:   f = ALU_MULH;
            F3_MULHSU: f = ALU_MULHSU;
            F3_MULHU:  f = ALU_MULHU;
            F3_DIV:    f = ALU_DIV;
            F3_DIVU:   f = ALU_DIVU;
            F3_REM:    f = ALU_REM;
            F3_REMU:   f = ALU_REMU;
            default:   f = NOTALU;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_core.sv
// Pure combinational RV64I/Zicsr/RV64M decoder producing the control bundle and an illegal flag.
module decode_core
    import pipes::*;
#(
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic [31:0] instr,
    output contral_t    ctl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd;
    op_t        op;
    alufunc_t   func;
    logic       bad;
    logic       writes_rd;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign rd            = instr[11:7];
    assign f3            = instr[14:12];
    assign f7            = instr[31:F7_FIRST];
    assign unused_fields = ^instr[24:15];

    always_comb begin
        op   = UNKNOWN;
        func = NOTALU;
        bad  = 1'b0;
        case (opcode)
            OPC_ALUI: begin
                op   = ALUI;
                func = alu_func(f3, instr[30]);
            end
            OPC_ALUIW: begin
                op   = ALUIW;
                func = alu_func(f3, instr[30]);
            end
            OPC_ALU, OPC_ALUW: begin
                op = (opcode == OPC_ALU) ? ALU : ALUW;
                if (f7 == F7_BASE) begin
                    func = alu_func(f3, 1'b0);
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    func = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    func = ALU_SRA;
                end else if (f7 == F7_MULDIV && MULDIV_EN) begin
                    func = muldiv_func(f3);
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_LUI: begin
                op   = LUI;
                func = ALU_ADD;
            end
            OPC_AUIPC: begin
                op   = AUIPC;
                func = ALU_ADD;
            end
            OPC_JAL: begin
                op   = JAL;
                func = ALU_ADD;
            end
            OPC_JALR: begin
                op   = JALR;
                func = ALU_ADD;
            end
            OPC_LOAD: begin
                op   = LD;
                func = ALU_ADD;
            end
            OPC_STORE: begin
                op   = SD;
                func = ALU_ADD;
            end
            // Branch compare: equality via subtract, ordering via set-less-than.
            OPC_BRANCH: begin
                op = BRANCH;
                case (f3)
                    F3_BEQ, F3_BNE:   func = ALU_SUB;
                    F3_BLT, F3_BGE:   func = ALU_SLT;
                    F3_BLTU, F3_BGEU: func = ALU_SLTU;
                    default:          bad  = 1'b1;
                endcase
            end
            // Only CSR accesses are accepted; ecall/ebreak/etc. (f3 000) and f3 100 are illegal.
            OPC_SYSTEM: begin
                op  = f3[2] ? CSRI : CSR;
                bad = (f3[1:0] == 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        writes_rd = !(op == BRANCH || op == SD);
        ctl       = CTL_NONE;
        illegal   = bad;
        if (!bad) begin
            ctl.op       = op;
            ctl.alufunc  = func;
            ctl.regwrite = writes_rd && (rd != 5'd0);
        end
    end

endmodule

// File: rtl/decode_buffer.sv
// Decode-at-push FIFO between fetch and execute; head entry is held in registers.
// DEPTH must be a power of two, at least 2.
module decode_buffer
    import pipes::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [63:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output contral_t               out_ctl,
    output logic [31:0]            out_instr,
    output logic [63:0]            out_pc,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    contral_t dec_ctl;
    logic     dec_illegal;
    entry_t   new_entry;
    logic     push;
    logic     pop;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    entry_t        head_q, head_d;

    decode_core #(
        .MULDIV_EN (MULDIV_EN)
    ) u_decode_core (
        .instr   (in_instr),
        .ctl     (dec_ctl),
        .illegal (dec_illegal)
    );

    assign new_entry = '{ctl: dec_ctl, illegal: dec_illegal, instr: in_instr, pc: in_pc};
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid_q && out_ready;

    // Next-state: pointers, occupancy and the registered head copy.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        head_d      = head_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            out_valid_d = (count_d != '0);
            // The incoming entry becomes the head only when nothing older remains.
            if (count_d != '0) begin
                head_d = (push && wr_ptr_q == rd_ptr_d) ? new_entry : mem_q[rd_ptr_d];
            end
        end
        in_ready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '{ctl: CTL_NONE, illegal: 1'b0, instr: '0, pc: '0};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_ctl     = head_q.ctl;
    assign out_instr   = head_q.instr;
    assign out_pc      = head_q.pc;
    assign out_illegal = head_q.illegal;
    assign count       = count_q;

endmodule

// File: tb/tb_decode_buffer.sv
// Bench for decode_buffer: queue model plus decoder reference, checked every cycle on two MULDIV_EN variants.
module tb_decode_buffer;

    import pipes::*;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic     ill;
        contral_t ctl;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    contral_t    out_ctl_a;
    logic [31:0] out_instr_a;
    logic [63:0] out_pc_a;
    logic [2:0]  count_a;

    logic        in_ready_b, out_valid_b, out_illegal_b;
    contral_t    out_ctl_b;
    logic [31:0] out_instr_b;
    logic [63:0] out_pc_b;
    logic [2:0]  count_b;

    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    bit   m_acc, m_pop, held_acc;
    exp_t e_a, e_b;
    ent_t q[$];

    logic [31:0] vecs [24] = '{
        32'h00500093, 32'h40208033, 32'h4020D0B3, 32'h40001033, 32'h04000033, 32'h022081B3,
        32'h0220C0BB, 32'h402080BB, 32'h0050809B, 32'h000122B7, 32'h00000297, 32'h008000EF,
        32'h000080E7, 32'h00000063, 32'h0020E463, 32'h00002063, 32'h0000B183, 32'h0020B023,
        32'h300110F3, 32'h300150F3, 32'h00000073, 32'h00004073, 32'hFFFFFFFF, 32'h0000000F
    };

    decode_buffer #(.DEPTH(DEPTH), .MULDIV_EN(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_ctl(out_ctl_a), .out_instr(out_instr_a), .out_pc(out_pc_a),
        .out_illegal(out_illegal_a), .count(count_a)
    );

    decode_buffer #(.DEPTH(DEPTH), .MULDIV_EN(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_ctl(out_ctl_b), .out_instr(out_instr_b), .out_pc(out_pc_b),
        .out_illegal(out_illegal_b), .count(count_b)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference decode written from the instruction-set rules.
    function automatic exp_t model_dec(input logic [31:0] ins, input bit md);
        exp_t       r;
        op_t        op;
        alufunc_t   af;
        bit         ill;
        logic [2:0] f3;
        logic [6:0] f7;
        alufunc_t   base [8];
        alufunc_t   mtab [8];
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        mtab = '{ALU_MULT, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        f3  = ins[14:12];
        f7  = ins[31:25];
        op  = UNKNOWN;
        af  = NOTALU;
        ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h1B: begin
                op = (ins[6:0] == 7'h13) ? ALUI : ALUIW;
                af = (f3 == 3'd5 && ins[30]) ? ALU_SRA : base[f3];
            end
            7'h33, 7'h3B: begin
                op = (ins[6:0] == 7'h33) ? ALU : ALUW;
                if (f7 == 7'h00)                     af = base[f3];
                else if (f7 == 7'h20 && f3 == 3'd0)  af = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5)  af = ALU_SRA;
                else if (f7 == 7'h01 && md)          af = mtab[f3];
                else                                 ill = 1'b1;
            end
            7'h37: begin op = LUI;   af = ALU_ADD; end
            7'h17: begin op = AUIPC; af = ALU_ADD; end
            7'h6F: begin op = JAL;   af = ALU_ADD; end
            7'h67: begin op = JALR;  af = ALU_ADD; end
            7'h03: begin op = LD;    af = ALU_ADD; end
            7'h23: begin op = SD;    af = ALU_ADD; end
            7'h63: begin
                op  = BRANCH;
                ill = (f3 == 3'd2 || f3 == 3'd3);
                af  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            7'h73: begin
                op  = f3[2] ? CSRI : CSR;
                ill = (f3 == 3'd0 || f3 == 3'd4);
            end
            default: ill = 1'b1;
        endcase
        r.ill          = ill;
        r.ctl.op       = ill ? UNKNOWN : op;
        r.ctl.alufunc  = ill ? NOTALU : af;
        r.ctl.regwrite = !ill && op != BRANCH && op != SD && ins[11:7] != 5'd0;
        return r;
    endfunction

    // Occupancy model: flush wins, pop frees the head, push only when not already full.
    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            m_acc = in_valid && (q.size() < DEPTH);
            m_pop = (q.size() != 0) && out_ready;
            if (m_pop) q.delete(0);
            if (m_acc) q.push_back('{in_instr, in_pc});
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("count_a", 64'(count_a), 64'(q.size()));
            chk("count_b", 64'(count_b), 64'(q.size()));
            chk("valid_a", 64'(out_valid_a), 64'(q.size() != 0));
            chk("valid_b", 64'(out_valid_b), 64'(q.size() != 0));
            chk("ready_a", 64'(in_ready_a), 64'(q.size() < DEPTH));
            chk("ready_b", 64'(in_ready_b), 64'(q.size() < DEPTH));
            if (q.size() != 0) begin
                e_a = model_dec(q[0].instr, 1'b1);
                e_b = model_dec(q[0].instr, 1'b0);
                chk("pc_a", out_pc_a, q[0].pc);
                chk("pc_b", out_pc_b, q[0].pc);
                chk("instr_a", 64'(out_instr_a), 64'(q[0].instr));
                chk("instr_b", 64'(out_instr_b), 64'(q[0].instr));
                chk("ctl_a", 64'(out_ctl_a), 64'(e_a.ctl));
                chk("ctl_b", 64'(out_ctl_b), 64'(e_b.ctl));
                chk("ill_a", 64'(out_illegal_a), 64'(e_a.ill));
                chk("ill_b", 64'(out_illegal_b), 64'(e_b.ill));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        repeat (2) tick();
        chk("rst_count", 64'(count_a), 64'd0);
        chk("rst_valid", 64'(out_valid_a), 64'd0);
        chk("rst_ready", 64'(in_ready_a), 64'd1);
        chk("rst_ctl", 64'(out_ctl_a), 64'(contral_t'{UNKNOWN, NOTALU, 1'b0}));
        chk("rst_instr", 64'(out_instr_a), 64'd0);
        chk("rst_pc", out_pc_a, 64'd0);
        chk("rst_ill", 64'(out_illegal_a), 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();

        push(32'h00500093, 64'h1000);
        chk("addi_valid", 64'(out_valid_a), 64'd1);
        chk("addi_ctl", 64'(out_ctl_a), 64'(contral_t'{ALUI, ALU_ADD, 1'b1}));
        chk("addi_ill", 64'(out_illegal_a), 64'd0);
        pop_one();

        push(32'h022081B3, 64'h1004);
        chk("mul_ctl_a", 64'(out_ctl_a), 64'(contral_t'{ALU, ALU_MULT, 1'b1}));
        chk("mul_ill_a", 64'(out_illegal_a), 64'd0);
        chk("mul_ctl_b", 64'(out_ctl_b), 64'(contral_t'{UNKNOWN, NOTALU, 1'b0}));
        chk("mul_ill_b", 64'(out_illegal_b), 64'd1);
        pop_one();

        push(32'h00000013, 64'h1008);
        chk("nop_ctl", 64'(out_ctl_a), 64'(contral_t'{ALUI, ALU_ADD, 1'b0}));
        pop_one();

        // Back-to-back stream: every vector occupies the head for exactly one cycle.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_instr = vecs[i];
            in_pc    = 64'h2000 + 64'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b0;

        // Fill to capacity with a fifth instruction waiting.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pc    = 64'h100 + 64'(16 * i);
            in_instr = 32'h00000013 | (32'(i + 1) << 7);
            tick();
        end
        chk("full_count", 64'(count_a), 64'd4);
        chk("full_ready", 64'(in_ready_a), 64'd0);
        in_pc    = 64'h140;
        in_instr = 32'h00500093;
        repeat (2) tick();
        chk("held_count", 64'(count_a), 64'd4);
        chk("held_head", out_pc_a, 64'h100);
        for (int i = 0; i < 5; i++) begin
            chk("drain_pc", out_pc_a, 64'h100 + 64'(16 * i));
            held_acc  = in_valid && in_ready_a;
            out_ready = 1'b1;
            tick();
            if (held_acc) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        chk("drained_count", 64'(count_a), 64'd0);

        push(32'h00100093, 64'h500);
        push(32'h00200093, 64'h504);
        out_ready = 1'b1;
        push(32'h00300093, 64'h508);
        out_ready = 1'b0;
        chk("pushpop_count", 64'(count_a), 64'd2);
        push(32'h00400093, 64'h50C);
        chk("three_count", 64'(count_a), 64'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        in_pc    = 64'h510;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count_a), 64'd0);
        chk("flush_valid", 64'(out_valid_a), 64'd0);
        tick();
        chk("flush_after", 64'(count_a), 64'd0);

        // Asynchronous reset in the middle of a cycle with three entries buffered.
        push(32'h00100093, 64'h600);
        push(32'h00200093, 64'h604);
        push(32'h00300093, 64'h608);
        chk("pre_rst_count", 64'(count_a), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(count_a), 64'd0);
        chk("arst_valid", 64'(out_valid_a), 64'd0);
        tick();
        reset = 1'b0;
        chk("arst_ready", 64'(in_ready_a), 64'd1);
        push(32'h00500093, 64'h3000);
        chk("arst_head_valid", 64'(out_valid_a), 64'd1);
        chk("arst_head_pc", out_pc_a, 64'h3000);
        pop_one();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
